cpu_run_monitor: RTL and testbench

Synthesizable run monitor that sits beside the pipeline and observes the IF-stage program counter and the hazard-unit freeze signal. It generalises bench-only PC printing and fixed-time stop into hardware. It counts cycles, fetches and stalls, detects program completion (a branch-to-self loop) or a cycle-budget timeout, and optionally records the accepted fetch PCs in a parametrised trace FIFO that a bench or debug port drains.

---
 rtl/cpu_run_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: counts cycles/fetches/stalls beside the pipeline, detects branch-to-self halt or cycle-budget timeout; `define CPU_RUN_MONITOR_TRACE_EN adds the fetch-PC trace FIFO.
// Outputs registered with 1-cycle latency (trace_pc is a combinational head read); never stalls the pipeline, trace pushes are dropped when full.
module cpu_run_monitor #(
    parameter int PC_WIDTH    = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int TRACE_DEPTH = 16,
    parameter int IDLE_LIMIT  = 8,
    parameter int TIMEOUT     = 300
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [PC_WIDTH-1:0]            pc_in,
    input  logic                           pc_valid,
    input  logic                           freeze,
    input  logic                           trace_rd,
    output logic [PC_WIDTH-1:0]            trace_pc,
    output logic                           trace_empty,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    output logic                           trace_ovf,
    output logic [CNT_WIDTH-1:0]           cycle_cnt,
    output logic [CNT_WIDTH-1:0]           fetch_cnt,
    output logic [CNT_WIDTH-1:0]           stall_cnt,
    output logic                           running,
    output logic                           done,
    output logic                           timed_out
);

    localparam int RPT_W = $clog2(IDLE_LIMIT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;
    localparam logic [1:0] S_TOUT = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TOUT_LAST = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [RPT_W-1:0]     RPT_LIM   = RPT_W'(IDLE_LIMIT);
    localparam logic [RPT_W-1:0]     RPT_ONE   = RPT_W'(1);

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [CNT_WIDTH-1:0] fetch_q, fetch_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic [PC_WIDTH-1:0]  last_pc_q, last_pc_d;
    logic [RPT_W-1:0]     rpt_q, rpt_d;
    logic                 running_q, done_q, tout_q;

    logic                 acc;
    logic                 live;
    logic                 same_pc;
    logic [RPT_W-1:0]     rpt_inc;
    logic                 halt_hit;
    logic                 tout_hit;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    assign acc      = pc_valid & ~freeze;
    // The IDLE->RUN edge is itself a counted, traced run cycle.
    assign live     = (state_q == S_RUN) | ((state_q == S_IDLE) & acc);
    assign same_pc  = (pc_in == last_pc_q);
    assign rpt_inc  = (rpt_q == RPT_LIM) ? rpt_q : rpt_q + RPT_ONE;
    assign halt_hit = acc & same_pc & (rpt_inc == RPT_LIM);
    assign tout_hit = (TIMEOUT != 0) && (cycle_q == TOUT_LAST);

    always_comb begin
        state_d   = state_q;
        cycle_d   = cycle_q;
        fetch_d   = fetch_q;
        stall_d   = stall_q;
        last_pc_d = last_pc_q;
        rpt_d     = rpt_q;

        if (live) begin
            cycle_d = sat_inc(cycle_q);
            if (acc) begin
                fetch_d   = sat_inc(fetch_q);
                last_pc_d = pc_in;
                rpt_d     = same_pc ? rpt_inc : '0;
            end
            if (pc_valid & freeze) begin
                stall_d = sat_inc(stall_q);
            end
        end

        case (state_q)
            S_IDLE: if (acc) state_d = S_RUN;
            // Halt outranks timeout when both land on the same edge.
            S_RUN: begin
                if (halt_hit) begin
                    state_d = S_HALT;
                end else if (tout_hit) begin
                    state_d = S_TOUT;
                end
            end
            default: state_d = state_q;
        endcase

        if (clear) begin
            state_d   = S_IDLE;
            cycle_d   = '0;
            fetch_d   = '0;
            stall_d   = '0;
            last_pc_d = '0;
            rpt_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cycle_q   <= '0;
            fetch_q   <= '0;
            stall_q   <= '0;
            last_pc_q <= '0;
            rpt_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            fetch_q   <= fetch_d;
            stall_q   <= stall_d;
            last_pc_q <= last_pc_d;
            rpt_q     <= rpt_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_HALT);
            tout_q    <= (state_d == S_TOUT);
        end
    end

    assign cycle_cnt = cycle_q;
    assign fetch_cnt = fetch_q;
    assign stall_cnt = stall_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timed_out = tout_q;

`ifdef CPU_RUN_MONITOR_TRACE_EN
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(TRACE_DEPTH);
    localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [PC_WIDTH-1:0] mem_q [TRACE_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q, count_d;
    logic                ovf_q, ovf_d;
    logic                push_req, push_en, pop_en;
    logic                fifo_empty, fifo_full;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign push_req   = acc & live;
    assign pop_en     = trace_rd & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_en    = push_req & (~fifo_full | pop_en);

    always_comb begin
        count_d = count_q;
        if (push_en & ~pop_en) begin
            count_d = count_q + OCC_ONE;
        end else if (pop_en & ~push_en) begin
            count_d = count_q - OCC_ONE;
        end
        ovf_d = ovf_q | (push_req & fifo_full & ~pop_en);
        if (clear) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_en & ~clear) begin
            mem_q[wr_ptr_q] <= pc_in;
        end
    end

    assign trace_pc    = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign trace_empty = fifo_empty;
    assign trace_count = count_q;
    assign trace_ovf   = ovf_q;
`else
    logic unused_trace_rd;
    assign unused_trace_rd = trace_rd;

    assign trace_pc    = '0;
    assign trace_empty = 1'b1;
    assign trace_count = '0;
    assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Randomised and directed bench for cpu_run_monitor against a queue-based reference model.
`timescale 1ns/1ps
module tb_cpu_run_monitor;

    localparam int PCW   = 32;
    localparam int CW    = 32;
    localparam int DEPTH = 16;
    localparam int LIMIT = 8;
    localparam int TMO   = 20;
`ifdef CPU_RUN_MONITOR_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif
    localparam longint unsigned CMAX = (64'd1 << CW) - 64'd1;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [PCW-1:0] pc_in;
    logic           pc_valid;
    logic           freeze;
    logic           trace_rd;
    logic [PCW-1:0] trace_pc;
    logic           trace_empty;
    logic [$clog2(DEPTH):0] trace_count;
    logic           trace_ovf;
    logic [CW-1:0]  cycle_cnt, fetch_cnt, stall_cnt;
    logic           running, done, timed_out;

    always #5 clk = ~clk;

    cpu_run_monitor #(
        .PC_WIDTH(PCW), .CNT_WIDTH(CW), .TRACE_DEPTH(DEPTH),
        .IDLE_LIMIT(LIMIT), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .pc_in(pc_in),
        .pc_valid(pc_valid), .freeze(freeze), .trace_rd(trace_rd),
        .trace_pc(trace_pc), .trace_empty(trace_empty), .trace_count(trace_count),
        .trace_ovf(trace_ovf), .cycle_cnt(cycle_cnt), .fetch_cnt(fetch_cnt),
        .stall_cnt(stall_cnt), .running(running), .done(done), .timed_out(timed_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: run phase as independent flags, counters as plain integers, trace as a queue.
    bit               m_started, m_halted, m_tout, m_ovf;
    longint unsigned  m_cycles, m_fetches, m_stalls;
    logic [PCW-1:0]   m_last;
    int               m_rep;
    logic [PCW-1:0]   m_fifo[$];

    function automatic longint unsigned sat(input longint unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_started = 0; m_halted = 0; m_tout = 0; m_ovf = 0;
        m_cycles = 0; m_fetches = 0; m_stalls = 0;
        m_last = '0; m_rep = 0;
        m_fifo.delete();
    endtask

    task automatic model_step(input bit v, input bit f, input bit rd, input bit clr, input logic [PCW-1:0] pc);
        bit acc, was_run, live, full, pop, same;
        longint unsigned old_cyc;
        if (clr) begin
            model_reset();
            return;
        end
        acc     = v && !f;
        was_run = m_started && !m_halted && !m_tout;
        live    = was_run || (!m_started && acc);
        full    = (m_fifo.size() == DEPTH);
        pop     = rd && (m_fifo.size() != 0);
        if (pop) void'(m_fifo.pop_front());
        if (live && acc) begin
            if (!full || pop) m_fifo.push_back(pc);
            else              m_ovf = 1;
        end
        same    = acc && (pc == m_last);
        old_cyc = m_cycles;
        if (live) begin
            m_cycles = sat(m_cycles);
            if (acc) m_fetches = sat(m_fetches);
            if (v && f) m_stalls = sat(m_stalls);
            if (acc) begin
                m_rep  = same ? m_rep + 1 : 0;
                m_last = pc;
            end
        end
        if (was_run) begin
            if (same && m_rep >= LIMIT) m_halted = 1;
            else if (TMO != 0 && old_cyc == TMO - 1) m_tout = 1;
        end else if (live) begin
            m_started = 1;
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".running"},   running,     m_started && !m_halted && !m_tout);
        check({ph, ".done"},      done,        m_halted);
        check({ph, ".timed_out"}, timed_out,   m_tout);
        check({ph, ".cycle"},     cycle_cnt,   m_cycles);
        check({ph, ".fetch"},     fetch_cnt,   m_fetches);
        check({ph, ".stall"},     stall_cnt,   m_stalls);
        check({ph, ".t_empty"},   trace_empty, TRACE_ON ? (m_fifo.size() == 0) : 1'b1);
        check({ph, ".t_count"},   trace_count, TRACE_ON ? m_fifo.size() : 0);
        check({ph, ".t_pc"},      trace_pc,    (TRACE_ON && m_fifo.size() != 0) ? m_fifo[0] : '0);
        check({ph, ".t_ovf"},     trace_ovf,   TRACE_ON ? m_ovf : 1'b0);
    endtask

    task automatic step(input bit v, input bit f, input bit rd, input bit clr,
                        input logic [PCW-1:0] pc, input string ph);
        pc_valid = v; freeze = f; trace_rd = rd; clear = clr; pc_in = pc;
        @(posedge clk);
        model_step(v, f, rd, clr, pc);
        #1;
        compare_all(ph);
    endtask

    logic [PCW-1:0] prev_pc;

    initial begin
        rst = 1'b0; clear = 1'b0; pc_in = '0; pc_valid = 1'b0; freeze = 1'b0; trace_rd = 1'b0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, '0, "idle");

        // Fill the trace with 0,4,..,0x3C, overflow, then simultaneous push/pop at full
        for (int i = 0; i < 16; i++) step(1, 0, 0, 0, PCW'(4 * i), "fill");
        check("fill.fetch16", fetch_cnt, 16);
        check("fill.count16", trace_count, TRACE_ON ? 16 : 0);
        step(1, 0, 0, 0, 32'h40, "ovf");
        check("ovf.flag", trace_ovf, TRACE_ON);
        check("ovf.head", trace_pc, 0);
        step(1, 0, 1, 0, 32'h44, "pushpop");
        check("pushpop.count", trace_count, TRACE_ON ? 16 : 0);
        for (int i = 0; i < 17; i++) step(0, 0, 1, 0, '0, "drain");
        check("drain.empty", trace_empty, 1);

        // Halt: 0x10, 0x14, three repeats, five frozen cycles, five more repeats
        step(0, 0, 0, 1, '0, "clear1");
        step(1, 0, 0, 0, 32'h10, "halt");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h14, "halt");
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 32'h14, "halt.frz");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 32'h14, "halt");
        check("halt.not_yet", done, 0);
        step(1, 0, 0, 0, 32'h14, "halt");
        check("halt.done", done, 1);
        check("halt.stall5", stall_cnt, 5);
        check("halt.fetch10", fetch_cnt, 10);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h14, "halt.after");
        check("halt.fetch_frozen", fetch_cnt, 10);

        // Timeout with distinct PCs every cycle
        step(0, 0, 0, 1, '0, "clear2");
        for (int i = 0; i < 19; i++) step(1, 0, 0, 0, PCW'(32'h1000 + 4 * i), "tmo");
        check("tmo.not_yet", timed_out, 0);
        step(1, 0, 0, 0, 32'h2000, "tmo");
        check("tmo.flag", timed_out, 1);
        check("tmo.cycle20", cycle_cnt, 20);
        step(0, 0, 0, 1, '0, "clear3");
        check("clear.cycle0", cycle_cnt, 0);
        check("clear.tout0", timed_out, 0);

        // Random traffic with a small PC set so repeats and halts occur
        prev_pc = 32'h200;
        for (int i = 0; i < 800; i++) begin
            bit v, f, rd, clr;
            logic [PCW-1:0] pc;
            v   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 30) == 0);
            pc  = ($urandom_range(0, 3) != 0) ? prev_pc : PCW'(32'h200 + 4 * $urandom_range(0, 3));
            prev_pc = pc;
            step(v, f, rd, clr, pc, "rand");
        end

        // Asynchronous reset between edges while running
        step(0, 0, 0, 1, '0, "clear4");
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, PCW'(32'h300 + 4 * i), "pre_arst");
        check("pre_arst.running", running, 1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        compare_all("arst");
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, '0, "post_arst");
        step(1, 0, 0, 0, 32'h400, "post_arst");
        check("post_arst.fetch1", fetch_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
